// File: rtl/seletor_writeback_if.sv
// Write-back stage bus: upstream beat (select inputs + handshake) and register-file side.
// Forwarding signals exist only when SELETOR_WRITEBACK_FORWARD_EN is defined.
interface seletor_writeback_if #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 13,
    parameter int unsigned REG_ADDR_WIDTH = 5
);
    logic                      in_valid;
    logic                      in_ready;
    logic [ADDR_WIDTH-1:0]     proximo_pc;
    logic [DATA_WIDTH-1:0]     escolhido_mem_to_reg;
    logic [DATA_WIDTH-1:0]     imediato;
    logic [DATA_WIDTH-1:0]     entrada_io;
    logic                      jalr;
    logic                      jump_al;
    logic                      lui;
    logic                      in_io;
    logic [REG_ADDR_WIDTH-1:0] reg_destino;
    logic                      reg_write;

    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_WIDTH-1:0]     wb_dado;
    logic [REG_ADDR_WIDTH-1:0] wb_reg;
    logic                      wb_write;

`ifdef SELETOR_WRITEBACK_FORWARD_EN
    logic                      fwd_valid;
    logic [REG_ADDR_WIDTH-1:0] fwd_reg;
    logic [DATA_WIDTH-1:0]     fwd_dado;
`endif

    // Stage side
    modport slave (
        input  in_valid, proximo_pc, escolhido_mem_to_reg, imediato, entrada_io,
        input  jalr, jump_al, lui, in_io, reg_destino, reg_write, out_ready,
        output in_ready, out_valid, wb_dado, wb_reg, wb_write
`ifdef SELETOR_WRITEBACK_FORWARD_EN
        , output fwd_valid, fwd_reg, fwd_dado
`endif
    );

    // Driver / observer side
    modport master (
        output in_valid, proximo_pc, escolhido_mem_to_reg, imediato, entrada_io,
        output jalr, jump_al, lui, in_io, reg_destino, reg_write, out_ready,
        input  in_ready, out_valid, wb_dado, wb_reg, wb_write
`ifdef SELETOR_WRITEBACK_FORWARD_EN
        , input fwd_valid, fwd_reg, fwd_dado
`endif
    );
endinterface

// File: rtl/seletor_writeback.sv
// Write-back data selector with a two-entry (output + skid) elastic buffer.
// Optional macro SELETOR_WRITEBACK_FORWARD_EN adds last-retired-write forwarding outputs.
module seletor_writeback #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 13,   // must not exceed DATA_WIDTH
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                clock,
    input  logic                reset,
    seletor_writeback_if.slave  bus
);
    typedef struct packed {
        logic [DATA_WIDTH-1:0]     dado;
        logic [REG_ADDR_WIDTH-1:0] wreg;
        logic                      write;
    } entry_t;

    entry_t in_entry;
    entry_t out_q,  out_d;
    entry_t skid_q, skid_d;
    logic   out_valid_q,  out_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   in_ready_q,   in_ready_d;
    logic   accept;
    logic   out_load;

    // Priority select of the write data; link value wins over IO, IO over LUI.
    always_comb begin : select_data
        in_entry.dado = bus.escolhido_mem_to_reg;
        if (bus.jalr || bus.jump_al) begin
            in_entry.dado = DATA_WIDTH'(bus.proximo_pc);
        end else if (bus.in_io) begin
            in_entry.dado = bus.entrada_io;
        end else if (bus.lui) begin
            in_entry.dado = bus.imediato;
        end
        in_entry.wreg  = bus.reg_destino;
        in_entry.write = bus.reg_write && (bus.reg_destino != '0);
    end

    assign accept   = bus.in_valid && in_ready_q;
    assign out_load = !out_valid_q || bus.out_ready;

    // Skid is full only while in_ready is low, so it never collides with an accept.
    always_comb begin : next_state
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (out_load) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = in_entry;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
                out_d.write = 1'b0;
            end
        end else if (accept) begin
            skid_d       = in_entry;
            skid_valid_d = 1'b1;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clock) begin : state_reg
        if (reset) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.wb_dado   = out_q.dado;
    assign bus.wb_reg    = out_q.wreg;
    assign bus.wb_write  = out_q.write;

`ifdef SELETOR_WRITEBACK_FORWARD_EN
    logic                      fwd_valid_q;
    logic [REG_ADDR_WIDTH-1:0] fwd_reg_q;
    logic [DATA_WIDTH-1:0]     fwd_dado_q;

    // Capture the most recent retired register-file write.
    always_ff @(posedge clock) begin : fwd_reg_p
        if (reset) begin
            fwd_valid_q <= 1'b0;
            fwd_reg_q   <= '0;
            fwd_dado_q  <= '0;
        end else if (out_valid_q && bus.out_ready && out_q.write) begin
            fwd_valid_q <= 1'b1;
            fwd_reg_q   <= out_q.wreg;
            fwd_dado_q  <= out_q.dado;
        end
    end

    assign bus.fwd_valid = fwd_valid_q;
    assign bus.fwd_reg   = fwd_reg_q;
    assign bus.fwd_dado  = fwd_dado_q;
`endif
endmodule

// File: doc/seletor_writeback.md
SELETOR_WRITEBACK -- requirements
Module: seletor_writeback

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_WIDTH, 32, register-file data width.
- ADDR_WIDTH, 13, PC width; DATA_WIDTH >= ADDR_WIDTH is mandatory.
- REG_ADDR_WIDTH, 5, register-file index width.

REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat.
- proximo_pc  in  ADDR_WIDTH  PC+1 link value.
- escolhido_mem_to_reg  in  DATA_WIDTH  ALU/memory result.
- imediato  in  DATA_WIDTH  LUI immediate.
- entrada_io  in  DATA_WIDTH  IO input word.
- jalr  in  1  JALR beat.
- jump_al  in  1  JAL beat.
- lui  in  1  LUI beat.
- in_io  in  1  IO-read beat.
- reg_destino  in  REG_ADDR_WIDTH  destination register.
- reg_write  in  1  beat writes the register file.
- out_valid  out  1  write-back beat valid.
- out_ready  in  1  register file accepts the beat.
- wb_dado  out  DATA_WIDTH  selected write data.
- wb_reg  out  REG_ADDR_WIDTH  write address.
- wb_write  out  1  write enable, qualified by out_valid.

Function
REQ-003 Data selection priority SHALL be: (jalr|jump_al) -> zero-extended proximo_pc; else in_io -> entrada_io; else lui -> imediato; else escolhido_mem_to_reg.
REQ-004 Selection SHALL be resolved when a beat is accepted (in_valid & in_ready) and stored with reg_destino and write intent.
REQ-005 Stored wb_write SHALL be reg_write & (reg_destino != 0); beats to register 0 still traverse the stage with wb_write=0.
REQ-006 The stage SHALL hold two entries, output register plus skid register; in_ready SHALL be a registered signal equal to "skid empty".
REQ-007 Output register SHALL load when out_valid=0 or out_ready=1; it loads from the skid register if the skid is full, else from the accepted input.
REQ-008 Latency SHALL be exactly 1 cycle from acceptance to out_valid with an empty stage and out_ready=1; throughput SHALL be one beat per cycle.
REQ-009 With out_valid=1 and out_ready=0, an accepted beat SHALL go to the skid register, and in_ready SHALL drop on the next cycle.
REQ-010 When accept and drain happen in the same cycle, no beat SHALL be lost, duplicated or reordered.
REQ-011 With out_valid=1 and out_ready=0, wb_dado, wb_reg and wb_write SHALL remain stable.
REQ-012 Select inputs SHALL be ignored in cycles with no accept.

Reset
REQ-013 While reset=1 at a clock edge: out_valid=0, skid empty, in_ready=1, wb_dado=0, wb_reg=0, wb_write=0.
REQ-014 Reset mid-operation SHALL discard both entries; no write-back beat SHALL appear in the cycle after reset.

Configuration
REQ-015 Macro SELETOR_WRITEBACK_FORWARD_EN, when defined, SHALL add three outputs:
- fwd_valid  out  1
- fwd_reg  out  REG_ADDR_WIDTH
- fwd_dado  out  DATA_WIDTH
REQ-016 With the macro defined, these outputs SHALL register the most recent beat retired with wb_write=1 (out_valid & out_ready & wb_write). They reset to 0 and hold until the next such retirement.
REQ-017 Without the macro, these ports SHALL NOT exist, and the behaviour of all other ports SHALL be identical.

Verification
REQ-018 Beat with jump_al=1, proximo_pc=13'h0ABC, reg_destino=31, reg_write=1, out_ready=1 -> next cycle: out_valid=1, wb_dado=32'h00000ABC, wb_reg=31, wb_write=1.
REQ-019 Beat with jalr=1, in_io=1, lui=1, proximo_pc=5 -> wb_dado=5. Beat with lui=1, in_io=1, entrada_io=7, imediato=9 -> wb_dado=7.
REQ-020 Three back-to-back beats (data 1, 2, 3) with out_ready=0 -> beats 1 and 2 are held, in_ready=0, beat 3 is not accepted until release. After out_ready=1, output order is 1, 2, 3 with no gaps or duplicates.
REQ-021 Beat with reg_destino=0, reg_write=1 -> out_valid=1 and wb_write=0. With the macro defined, fwd_* remain unchanged.
REQ-022 Assert reset with both entries full -> next cycle: out_valid=0, in_ready=1. A new beat then retires with 1-cycle latency.
REQ-023 With the macro defined: retire a write to reg 4 with data 32'hDEADBEEF, then a non-writing beat -> fwd_valid=1, fwd_reg=4, fwd_dado=32'hDEADBEEF persist.
